checkout_calculator: RTL
========================

Name: checkout_calculator

Overview:
Clocked, parametrised price-lookup calculator for the checkout environment. It holds a DEPTH-entry price table keyed by item string. It accepts LOAD, EQUALS, ADD and CLEAR commands over a valid/ready handshake, and answers each with a one-cycle response pulse. New relative to the previous generation: bounded table with full detection, a running-sum mode, saturating arithmetic with typed error codes, and a sequential table scan.

Parameters:
ITEM_W, 640, item key width in bits (80 ASCII chars)
QTY_W, 8, quantity width
PRICE_W, 16, unit price width in cents
TOTAL_W, 16, total/accumulator width in cents
DEPTH, 16, price table entries (>=1)
ERR_TOTAL, 9999, value driven on total_in_cents after an EQUALS miss

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  2  00 LOAD, 01 EQUALS, 10 ADD, 11 CLEAR
item  input  ITEM_W  item key
qty  input  QTY_W  quantity (EQUALS/ADD)
price_in_cents  input  PRICE_W  unit price (LOAD)
rsp_valid  output  1  one-cycle pulse: command complete
total_in_cents  output  TOTAL_W  current total / accumulator
err  output  1  last completed command failed
err_code  output  2  00 none, 01 NOT_FOUND, 10 FULL, 11 OVERFLOW

Behaviour:
- Reset (reset_n low, async): table emptied (count=0), FSM=IDLE, cmd_ready=1, rsp_valid=0, total_in_cents=0, err=0, err_code=00.
- Reset mid-operation aborts the command. No rsp_valid is produced.
- FSM states: IDLE, SCAN, RESP.
- cmd_ready=1 only in IDLE.
- Accept on cmd_valid&&cmd_ready. Operands are registered at accept; later input changes are ignored.
- CLEAR: IDLE->RESP. Sets total=0, err=0, code=00. Table preserved. rsp_valid in cycle 1 (accept = cycle 0).
- LOAD/EQUALS/ADD: IDLE->SCAN, idx=0.
- SCAN compares entry[idx] with the stored item, one entry per cycle, over entries 0..count-1 only.
  - Hit at idx=k -> RESP.
  - idx reaches count -> miss -> RESP.
- rsp_valid is asserted in cycle N+2, where N=k on hit and N=count on miss.
- RESP lasts one cycle, then IDLE. cmd_ready rises in the cycle after rsp_valid.
- total_in_cents, err and err_code update on the same edge that raises rsp_valid. They then hold until the next response.
- LOAD:
  - Hit: overwrite price.
  - Miss with count<DEPTH: write at index count, count++.
  - Miss with count==DEPTH: table unchanged, err=1, code FULL.
  - total unchanged. Success sets err=0.
- Line value = qty*price at full width, QTY_W+PRICE_W bits, unsigned.
- EQUALS:
  - Hit: total = line, err=0.
  - If line > 2^TOTAL_W-1: total = all ones, err=1, code OVERFLOW.
  - Miss: total = ERR_TOTAL, err=1, code NOT_FOUND.
- ADD:
  - Hit: total = total + line, computed at full width.
  - Sum > max: total saturates to all ones, err=1, code OVERFLOW.
  - Miss: total unchanged, err=1, code NOT_FOUND.
- Keys compare on all ITEM_W bits. Duplicate keys never exist.
- The table never shrinks except on reset.

Test Plan:
1. Reset, LOAD "apple"=125, EQUALS "apple" qty 3 -> rsp_valid at cycle 2, total=375, err=0, code=00.
2. LOAD "a".."p" (16 items), then LOAD "q"=1 -> err=1, code FULL, count stays 16. EQUALS "q" qty 1 -> total=9999, NOT_FOUND, rsp_valid at cycle 18.
3. LOAD "x"=1000; ADD "x" qty 30 (total=30000); ADD "x" qty 40 -> total=65535, OVERFLOW. CLEAR -> total=0, err=0, rsp_valid at cycle 1.
4. LOAD "pen"=50, LOAD "pen"=70, EQUALS "pen" qty 2 -> total=140. Count remains 1, and a further 15 distinct LOADs all succeed.
5. EQUALS "x" qty 255 with price 300 -> line 76500 > 65535 -> total=65535, OVERFLOW. ADD of an unknown item -> total unchanged, NOT_FOUND.
6. Hold cmd_valid with operands changing mid-scan: cmd_ready stays 0 and the result uses the accepted operands. Assert reset_n low mid-SCAN: no rsp_valid, outputs zero, table empty.

Source files
------------

// File: rtl/checkout_calculator.sv
// rtl/checkout_calculator.sv - price-table checkout calculator with sequential scan and saturating totals
module checkout_calculator #(
  parameter int ITEM_W    = 640,
  parameter int QTY_W     = 8,
  parameter int PRICE_W   = 16,
  parameter int TOTAL_W   = 16,
  parameter int DEPTH     = 16,
  parameter int ERR_TOTAL = 9999
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ITEM_W-1:0]  item,
  input  logic [QTY_W-1:0]   qty,
  input  logic [PRICE_W-1:0] price_in_cents,
  output logic               rsp_valid,
  output logic [TOTAL_W-1:0] total_in_cents,
  output logic               err,
  output logic [1:0]         err_code
);

  localparam int LINE_W = QTY_W + PRICE_W;
  localparam int SUM_W  = ((LINE_W > TOTAL_W) ? LINE_W : TOTAL_W) + 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_EQUALS = 2'b01;
  localparam logic [1:0] OP_ADD    = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_NOTFOUND = 2'b01;
  localparam logic [1:0] CODE_FULL     = 2'b10;
  localparam logic [1:0] CODE_OVERFLOW = 2'b11;

  localparam logic [TOTAL_W-1:0] ERR_VAL   = TOTAL_W'(ERR_TOTAL);
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = {TOTAL_W{1'b1}};
  localparam logic [SUM_W-1:0]   MAX_EXT   = SUM_W'(TOTAL_MAX);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t state, state_nxt;

  logic [1:0]         op_r;
  logic [ITEM_W-1:0]  item_r;
  logic [QTY_W-1:0]   qty_r;
  logic [PRICE_W-1:0] price_r;
  logic [CNT_W-1:0]   idx;
  logic [CNT_W-1:0]   count;

  logic [ITEM_W-1:0]  keys   [DEPTH];
  logic [PRICE_W-1:0] prices [DEPTH];

  logic [ITEM_W-1:0]  cur_key;
  logic [PRICE_W-1:0] cur_price;
  logic               in_range;
  logic               hit;
  logic               done;
  logic               accept;
  logic               has_room;
  logic [LINE_W-1:0]  line;
  logic [SUM_W-1:0]   line_ext;
  logic [SUM_W-1:0]   sum_ext;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign has_room  = (count < CNT_W'(DEPTH));

  // Select the table entry under the scan pointer; idx may equal DEPTH, in which case nothing matches
  always_comb begin
    cur_key   = '0;
    cur_price = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx == CNT_W'(i)) begin
        cur_key   = keys[i];
        cur_price = prices[i];
      end
    end
  end

  // Scan compare plus full-width line value and running sum
  always_comb begin
    in_range = (idx < count);
    hit      = in_range && (cur_key == item_r);
    done     = (state == SCAN) && (hit || !in_range);
    line     = LINE_W'(qty_r) * LINE_W'(cur_price);
    line_ext = SUM_W'(line);
    sum_ext  = SUM_W'(total_in_cents) + line_ext;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: CLEAR skips the scan, everything else walks the table
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (cmd_op == OP_CLEAR) ? RESP : SCAN;
      SCAN: if (hit || !in_range) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, scan pointer, entry count and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r           <= OP_LOAD;
      item_r         <= '0;
      qty_r          <= '0;
      price_r        <= '0;
      idx            <= '0;
      count          <= '0;
      total_in_cents <= '0;
      err            <= 1'b0;
      err_code       <= CODE_NONE;
    end else begin
      if (accept) begin
        op_r    <= cmd_op;
        item_r  <= item;
        qty_r   <= qty;
        price_r <= price_in_cents;
        idx     <= '0;
        if (cmd_op == OP_CLEAR) begin
          total_in_cents <= '0;
          err            <= 1'b0;
          err_code       <= CODE_NONE;
        end
      end else if (state == SCAN && !done) begin
        idx <= idx + CNT_W'(1);
      end

      if (done) begin
        case (op_r)
          OP_LOAD: begin
            if (hit) begin
              err      <= 1'b0;
              err_code <= CODE_NONE;
            end else if (has_room) begin
              count    <= count + CNT_W'(1);
              err      <= 1'b0;
              err_code <= CODE_NONE;
            end else begin
              err      <= 1'b1;
              err_code <= CODE_FULL;
            end
          end
          OP_EQUALS: begin
            if (!hit) begin
              total_in_cents <= ERR_VAL;
              err            <= 1'b1;
              err_code       <= CODE_NOTFOUND;
            end else if (line_ext > MAX_EXT) begin
              total_in_cents <= TOTAL_MAX;
              err            <= 1'b1;
              err_code       <= CODE_OVERFLOW;
            end else begin
              total_in_cents <= TOTAL_W'(line_ext);
              err            <= 1'b0;
              err_code       <= CODE_NONE;
            end
          end
          OP_ADD: begin
            if (!hit) begin
              err      <= 1'b1;
              err_code <= CODE_NOTFOUND;
            end else if (sum_ext > MAX_EXT) begin
              total_in_cents <= TOTAL_MAX;
              err            <= 1'b1;
              err_code       <= CODE_OVERFLOW;
            end else begin
              total_in_cents <= TOTAL_W'(sum_ext);
              err            <= 1'b0;
              err_code       <= CODE_NONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Table storage: on a LOAD hit idx points at the match, on a miss idx equals count (next free slot)
  always_ff @(posedge clk) begin
    if (done && op_r == OP_LOAD && (hit || has_room)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (idx == CNT_W'(i)) begin
          keys[i]   <= item_r;
          prices[i] <= price_r;
        end
      end
    end
  end

endmodule
